// File: rtl/cf_sweep_ctrl_pkg.sv
// Shared definitions for the CF_1 truth-table sweep controller.
package cf_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } cf_state_e;

  // Default function width and the number of vectors it implies.
  localparam int N_IN_DEF = 4;
  localparam int N_VEC    = 2 ** N_IN_DEF;

  // Bit positions of the function inputs on abcd_o (a is the MSB).
  localparam int ABCD_A_BIT = N_IN_DEF - 1;
  localparam int ABCD_B_BIT = N_IN_DEF - 2;
  localparam int ABCD_C_BIT = N_IN_DEF - 3;
  localparam int ABCD_D_BIT = 0;

  // Width of the settle-time counter (SETTLE ranges over 0..255).
  localparam int SETTLE_W = 8;

endpackage

// File: rtl/cf_sweep_ctrl_if.sv
// Control/result bus between the test master and the sweep controller.
interface cf_sweep_ctrl_if #(
  parameter int N_IN = 4
);
  localparam int NV = 2 ** N_IN;

  logic            start;
  logic            abort;
  logic [NV-1:0]   exp_tt;
  logic            busy;
  logic            done;
  logic            pass;
  logic [NV-1:0]   tt_o;
  logic [N_IN:0]   fail_cnt;
  logic [N_IN-1:0] fail_idx;

  modport master (
    output start, abort, exp_tt,
    input  busy, done, pass, tt_o, fail_cnt, fail_idx
  );

  modport slave (
    input  start, abort, exp_tt,
    output busy, done, pass, tt_o, fail_cnt, fail_idx
  );

endinterface

// File: rtl/cf_sweep_ctrl_settle.sv
// Down-counter that paces the settle window before each sample.
module cf_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load takes priority; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cf_sweep_ctrl.sv
// Exhaustive truth-table sweep of the CF_1 function block with
// on-the-fly comparison against an expected table.
module cf_sweep_ctrl
  import cf_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  cf_sweep_ctrl_if.slave    bus,
  output logic [N_IN-1:0]   abcd_o,
  input  logic              y_i
);

  localparam int                 NV        = 2 ** N_IN;
  localparam logic [N_IN-1:0]    LAST_IDX  = {N_IN{1'b1}};
  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);

  cf_state_e       state_q;
  logic [N_IN-1:0] idx_q;
  logic [NV-1:0]   exp_q;
  logic [NV-1:0]   tt_q;
  logic [N_IN:0]   fail_cnt_q;
  logic [N_IN-1:0] fail_idx_q;
  logic            pass_q;
  logic            busy_q;
  logic            done_q;
  logic [N_IN-1:0] abcd_q;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;
  logic mismatch;

  cf_settle_timer #(
    .W (SETTLE_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (SETTLE_LD),
    .zero_o     (tmr_zero)
  );

  assign mismatch = (y_i != exp_q[idx_q]);

  // Reload the settle timer whenever a vector starts, count it down while settling.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE:   tmr_load = bus.start && !bus.abort;
      ST_SETTLE: tmr_dec  = !bus.abort && !tmr_zero;
      ST_SAMPLE: tmr_load = !bus.abort && (idx_q != LAST_IDX);
      default:   ;
    endcase
  end

  // Sequencer with registered outputs; abort returns to idle but keeps partial results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      exp_q      <= '0;
      tt_q       <= '0;
      fail_cnt_q <= '0;
      fail_idx_q <= '0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abcd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          abcd_q <= '0;
          if (bus.start && !bus.abort) begin
            exp_q      <= bus.exp_tt;
            tt_q       <= '0;
            fail_cnt_q <= '0;
            fail_idx_q <= '0;
            pass_q     <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (bus.abort) begin
            abcd_q  <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (tmr_zero) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (bus.abort) begin
            abcd_q  <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tt_q[idx_q] <= y_i;
            if (mismatch) begin
              fail_cnt_q <= fail_cnt_q + 1'b1;
              if (fail_cnt_q == '0) begin
                fail_idx_q <= idx_q;
              end
            end
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              pass_q  <= (fail_cnt_q == '0) && !mismatch;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              abcd_q  <= idx_q + 1'b1;
              state_q <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          abcd_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign abcd_o       = abcd_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.tt_o     = tt_q;
  assign bus.fail_cnt = fail_cnt_q;
  assign bus.fail_idx = fail_idx_q;

endmodule

// File: tb/tb_cf_sweep_ctrl.sv
// Directed self-checking bench for cf_sweep_ctrl (SETTLE=2 and SETTLE=0 builds).
module tb_cf_sweep_ctrl;
  import cf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cf_sweep_ctrl_if #(.N_IN(4)) bus ();
  cf_sweep_ctrl_if #(.N_IN(4)) bus0 ();

  logic [3:0] abcd;
  logic [3:0] abcd0;
  logic       y;
  logic       y0;
  int         modeSel = 0;
  int         errors  = 0;
  int         checks  = 0;

  cf_sweep_ctrl #(.N_IN(4), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .abcd_o(abcd), .y_i(y));

  cf_sweep_ctrl #(.N_IN(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .abcd_o(abcd0), .y_i(y0));

  // Function-block models: 0 = 4-input AND, 1 = stuck-at-0, 2 = parity.
  always_comb begin
    case (modeSel)
      0:       y = abcd[ABCD_A_BIT] & abcd[ABCD_B_BIT] & abcd[ABCD_C_BIT] & abcd[ABCD_D_BIT];
      2:       y = ^abcd;
      default: y = 1'b0;
    endcase
  end
  assign y0 = &abcd0;

  task automatic applyStart();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  // Start a sweep, wait for done, then let the DUT return to idle.
  task automatic applyStimulus(input logic [N_VEC-1:0] expTt, output int cyc);
    bus.exp_tt = expTt;
    applyStart();
    waitDone(200, cyc);
    repeat (1) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.pass});
    end
    checks++;
    if (bus.tt_o !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_tt: got %h expected 0000", bus.tt_o);
    end
    checks++;
    if (bus.fail_cnt !== 5'd0) begin
      errors++; $display("[TB] FAIL reset_fail_cnt: got %0d expected 0", bus.fail_cnt);
    end
    checks++;
    if (bus.fail_idx !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_fail_idx: got %0d expected 0", bus.fail_idx);
    end
    checks++;
    if (abcd !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_abcd: got %0d expected 0", abcd);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_and_pass();
    int stepBad = 0;
    int doneAt  = -1;
    int doneHi  = 0;
    modeSel    = 0;
    bus.exp_tt = 16'h8000;
    applyStart();
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        doneHi++;
        if (doneAt < 0) doneAt = c;
      end
      if (c <= 63 && abcd !== 4'(c / 4)) stepBad++;
    end
    checks++;
    if (stepBad != 0) begin
      errors++; $display("[TB] FAIL and_abcd_steps: got %0d bad cycles expected 0", stepBad);
    end
    checks++;
    if (doneAt != 64) begin
      errors++; $display("[TB] FAIL and_done_cycle: got %0d expected 64", doneAt);
    end
    checks++;
    if (doneHi != 1) begin
      errors++; $display("[TB] FAIL and_done_width: got %0d expected 1", doneHi);
    end
    checks++;
    if (bus.pass !== 1'b1) begin
      errors++; $display("[TB] FAIL and_pass: got %b expected 1", bus.pass);
    end
    checks++;
    if (bus.tt_o !== 16'h8000) begin
      errors++; $display("[TB] FAIL and_tt: got %h expected 8000", bus.tt_o);
    end
    checks++;
    if (bus.fail_cnt !== 5'd0 || bus.fail_idx !== 4'd0) begin
      errors++; $display("[TB] FAIL and_fail_info: got cnt=%0d idx=%0d expected cnt=0 idx=0", bus.fail_cnt, bus.fail_idx);
    end
    checks++;
    if (bus.busy !== 1'b0 || abcd !== 4'd0) begin
      errors++; $display("[TB] FAIL and_idle_after: got busy=%b abcd=%0d expected busy=0 abcd=0", bus.busy, abcd);
    end
  endtask

  task automatic test_mismatch();
    int cyc;
    modeSel = 0;
    applyStimulus(16'h8001, cyc);
    checks++;
    if (cyc != 64) begin
      errors++; $display("[TB] FAIL mis_done_cycle: got %0d expected 64", cyc);
    end
    checks++;
    if (bus.pass !== 1'b0 || bus.tt_o !== 16'h8000) begin
      errors++; $display("[TB] FAIL mis_pass_tt: got pass=%b tt=%h expected pass=0 tt=8000", bus.pass, bus.tt_o);
    end
    checks++;
    if (bus.fail_cnt !== 5'd1 || bus.fail_idx !== 4'd0) begin
      errors++; $display("[TB] FAIL mis_fail_info: got cnt=%0d idx=%0d expected cnt=1 idx=0", bus.fail_cnt, bus.fail_idx);
    end
  endtask

  task automatic test_stuck0();
    int cyc;
    modeSel = 1;
    applyStimulus(16'h8000, cyc);
    checks++;
    if (bus.pass !== 1'b0 || bus.tt_o !== 16'h0000) begin
      errors++; $display("[TB] FAIL stuck_pass_tt: got pass=%b tt=%h expected pass=0 tt=0000", bus.pass, bus.tt_o);
    end
    checks++;
    if (bus.fail_cnt !== 5'd1 || bus.fail_idx !== 4'd15) begin
      errors++; $display("[TB] FAIL stuck_fail_info: got cnt=%0d idx=%0d expected cnt=1 idx=15", bus.fail_cnt, bus.fail_idx);
    end
  endtask

  task automatic test_parity();
    int cyc;
    modeSel = 2;
    applyStimulus(16'h0000, cyc);
    checks++;
    if (bus.pass !== 1'b0 || bus.tt_o !== 16'h6996) begin
      errors++; $display("[TB] FAIL par_pass_tt: got pass=%b tt=%h expected pass=0 tt=6996", bus.pass, bus.tt_o);
    end
    checks++;
    if (bus.fail_cnt !== 5'd8 || bus.fail_idx !== 4'd1) begin
      errors++; $display("[TB] FAIL par_fail_info: got cnt=%0d idx=%0d expected cnt=8 idx=1", bus.fail_cnt, bus.fail_idx);
    end
  endtask

  task automatic test_abort();
    int doneSeen = 0;
    int cyc;
    modeSel    = 0;
    bus.exp_tt = 16'h8000;
    applyStart();
    repeat (20) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || abcd !== 4'd0) begin
      errors++; $display("[TB] FAIL abort_idle: got busy=%b abcd=%0d expected busy=0 abcd=0", bus.busy, abcd);
    end
    @(negedge clk);
    bus.abort = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) doneSeen++;
    end
    checks++;
    if (doneSeen != 0 || bus.pass !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_no_done: got done=%0d pass=%b expected done=0 pass=0", doneSeen, bus.pass);
    end
    @(negedge clk);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_beats_start: got busy=%b expected 0", bus.busy);
    end
    applyStimulus(16'h8000, cyc);
    checks++;
    if (cyc != 64 || bus.pass !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_rerun: got done_cycle=%0d pass=%b expected 64 and 1", cyc, bus.pass);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    modeSel    = 2;
    bus.exp_tt = 16'h0000;
    applyStart();
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (bus.fail_cnt !== 5'd3 || bus.tt_o !== 16'h0016) begin
      errors++; $display("[TB] FAIL areset_partial: got cnt=%0d tt=%h expected cnt=3 tt=0016", bus.fail_cnt, bus.tt_o);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.pass} !== 3'b000 || abcd !== 4'd0 || bus.tt_o !== 16'h0000 || bus.fail_cnt !== 5'd0) begin
      errors++; $display("[TB] FAIL areset_clear: got busy=%b abcd=%0d tt=%h cnt=%0d expected all 0", bus.busy, abcd, bus.tt_o, bus.fail_cnt);
    end
    @(negedge clk);
    rst     = 1'b0;
    modeSel = 0;
    applyStimulus(16'h8000, cyc);
    checks++;
    if (cyc != 64 || bus.pass !== 1'b1) begin
      errors++; $display("[TB] FAIL areset_rerun: got done_cycle=%0d pass=%b expected 64 and 1", cyc, bus.pass);
    end
  endtask

  task automatic test_back_to_back();
    int doneAt[$];
    int idleAt = -1;
    modeSel    = 0;
    bus.exp_tt = 16'h8000;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) doneAt.push_back(c);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (doneAt.size() != 3) begin
      errors++; $display("[TB] FAIL b2b_pulse_count: got %0d expected 3", doneAt.size());
    end else begin
      checks++;
      if (doneAt[0] != 64 || doneAt[1] != 130 || doneAt[2] != 196) begin
        errors++; $display("[TB] FAIL b2b_done_cycles: got %0d,%0d,%0d expected 64,130,196", doneAt[0], doneAt[1], doneAt[2]);
      end
    end
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (bus.busy === 1'b0) begin
        idleAt = c;
        break;
      end
    end
    checks++;
    if (idleAt < 0 || bus.pass !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_final_idle: got idle_at=%0d pass=%b expected idle and pass=1", idleAt, bus.pass);
    end
  endtask

  task automatic test_settle_zero();
    int doneAt = -1;
    @(negedge clk);
    bus0.start = 1'b1;
    @(posedge clk);
    #1;
    bus0.start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (bus0.done === 1'b1 && doneAt < 0) doneAt = c;
    end
    checks++;
    if (doneAt != 32) begin
      errors++; $display("[TB] FAIL s0_done_cycle: got %0d expected 32", doneAt);
    end
    checks++;
    if (bus0.pass !== 1'b1 || bus0.tt_o !== 16'h8000) begin
      errors++; $display("[TB] FAIL s0_result: got pass=%b tt=%h expected pass=1 tt=8000", bus0.pass, bus0.tt_o);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.exp_tt  = '0;
    bus0.start  = 1'b0;
    bus0.abort  = 1'b0;
    bus0.exp_tt = 16'h8000;
    test_reset();
    test_and_pass();
    test_mismatch();
    test_stuck0();
    test_parity();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_settle_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
